// File: rtl/div8_seq_if.sv
// -----------------------------------------------------------------------------
// div8_seq_if
// Handshake and operand/result bundle for the sequential divide unit.
//   start      controller -> divider  request pulse
//   dividend   controller -> divider  unsigned dividend (WIDTH)
//   divisor    controller -> divider  unsigned divisor  (WIDTH)
//   busy       divider -> controller  operation in progress
//   done       divider -> controller  one-cycle result-valid pulse
//   quotient   divider -> controller  unsigned quotient (WIDTH)
//   remainder  divider -> controller  unsigned remainder (WIDTH)
//   C / V / Z  divider -> controller  inexact / divide-by-zero / zero quotient
// Modports: master = controller side, slave = divider side.
// -----------------------------------------------------------------------------
interface div8_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             C;
  logic             V;
  logic             Z;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, C, V, Z
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, C, V, Z
  );
endinterface

// File: rtl/div8_seq.sv
// -----------------------------------------------------------------------------
// div8_seq
// Multi-cycle unsigned restoring divider, one quotient bit per clock, MSB
// first. Flags follow the adder convention of the ALU:
//   C = remainder nonzero, V = divide-by-zero, Z = quotient zero.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; discards any in-flight operation
//   bus  div8_seq_if.slave: start/dividend/divisor in,
//        busy/done/quotient/remainder/C/V/Z out
// Timing: a start accepted on edge k with a nonzero divisor gives busy for
// WIDTH cycles and done in the cycle after edge k+WIDTH; a zero divisor
// skips RUN and gives done in the cycle after edge k. Results hold until
// the next operation completes.
// -----------------------------------------------------------------------------
module div8_seq #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  div8_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_dividend;   // shifts left; MSB is the next bit to bring in
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH:0]   r_partial;    // WIDTH+1 bits so the shifted value never overflows
  logic [WIDTH-1:0] r_quot_shift;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_c;
  logic             r_v;
  logic             r_z;

  logic             w_busy;
  logic             w_done;
  logic             w_accept_run;
  logic             w_accept_zero;
  logic             w_finish;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;
  logic [WIDTH:0]   w_partial_next;
  logic [WIDTH-1:0] w_quot_next;

  // One restoring step. The subtraction is one bit wider than the partial
  // remainder so its top bit is a clean borrow indicator.
  assign w_shifted      = {r_partial[WIDTH-1:0], r_dividend[WIDTH-1]};
  assign w_trial        = {1'b0, w_shifted} - {2'b00, r_divisor};
  assign w_borrow       = w_trial[WIDTH+1];
  assign w_partial_next = w_borrow ? w_shifted : w_trial[WIDTH:0];
  assign w_quot_next    = {r_quot_shift[WIDTH-2:0], ~w_borrow};

  // NOTE: state and data registers use non-blocking assignments so every
  // flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_next  = r_state;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_accept_run  = 1'b0;
    w_accept_zero = 1'b0;
    w_finish      = 1'b0;
    case (r_state)
      ST_IDLE, ST_FIN: begin
        // FIN accepts a new start exactly like IDLE for back-to-back use.
        w_done       = (r_state == ST_FIN);
        w_state_next = ST_IDLE;
        if (bus.start) begin
          if (bus.divisor != '0) begin
            w_accept_run = 1'b1;
            w_state_next = ST_RUN;
          end else begin
            w_accept_zero = 1'b1;
            w_state_next  = ST_FIN;
          end
        end
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (r_count == CNT_W'(WIDTH - 1)) begin
          w_finish     = 1'b1;
          w_state_next = ST_FIN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: every datapath register, not just the FSM, is cleared on reset so
  // an aborted operation leaves no residue visible on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dividend   <= '0;
      r_divisor    <= '0;
      r_partial    <= '0;
      r_quot_shift <= '0;
      r_count      <= '0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_c          <= 1'b0;
      r_v          <= 1'b0;
      r_z          <= 1'b0;
    end else if (w_accept_run) begin
      // Result registers are left alone: they hold until this op completes.
      r_dividend   <= bus.dividend;
      r_divisor    <= bus.divisor;
      r_partial    <= '0;
      r_quot_shift <= '0;
      r_count      <= '0;
    end else if (w_accept_zero) begin
      r_quotient   <= '1;
      r_remainder  <= bus.dividend;
      r_c          <= (bus.dividend != '0);
      r_v          <= 1'b1;
      r_z          <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_dividend   <= {r_dividend[WIDTH-2:0], 1'b0};
      r_partial    <= w_partial_next;
      r_quot_shift <= w_quot_next;
      r_count      <= r_count + CNT_W'(1);
      if (w_finish) begin
        r_quotient  <= w_quot_next;
        r_remainder <= w_partial_next[WIDTH-1:0];
        r_c         <= (w_partial_next[WIDTH-1:0] != '0);
        r_v         <= 1'b0;
        r_z         <= (w_quot_next == '0);
      end
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.C         = r_c;
  assign bus.V         = r_v;
  assign bus.Z         = r_z;

endmodule

// File: tb/tb_div8_seq.sv
// -----------------------------------------------------------------------------
// tb_div8_seq
// Directed bench for div8_seq (WIDTH = 8). Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, well away from the edge.
// -----------------------------------------------------------------------------
module tb_div8_seq;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 50;

  logic clk;
  logic rst;

  int tests_run;
  int tests_failed;
  int overlap_seen;

  div8_seq_if #(.WIDTH(WIDTH)) u_if ();

  div8_seq #(.WIDTH(WIDTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (u_if.busy && u_if.done) overlap_seen++;
  endtask

  // Present operands with start high for exactly one sampling edge.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    u_if.start    = 1'b1;
    u_if.dividend = a;
    u_if.divisor  = b;
    step();
    u_if.start = 1'b0;
  endtask

  // Count edges until done is seen, and cycles in which busy was high.
  task automatic wait_done(output int n, output int busy_cnt);
    n        = 0;
    busy_cnt = u_if.busy ? 1 : 0;
    while (!u_if.done && n < MAX_WAIT) begin
      step();
      n++;
      if (u_if.busy) busy_cnt++;
    end
    if (!u_if.done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input int q, input int r,
                              input logic c, input logic v, input logic z);
    check({tag, "_q"}, 32'(u_if.quotient),  32'(q));
    check({tag, "_r"}, 32'(u_if.remainder), 32'(r));
    check({tag, "_C"}, 32'(u_if.C), 32'(c));
    check({tag, "_V"}, 32'(u_if.V), 32'(v));
    check({tag, "_Z"}, 32'(u_if.Z), 32'(z));
  endtask

  initial begin
    int n;
    int bc;
    int done_cnt;

    tests_run     = 0;
    tests_failed  = 0;
    overlap_seen  = 0;
    u_if.start    = 1'b0;
    u_if.dividend = '0;
    u_if.divisor  = '0;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check_result("rst", 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    // 100 / 7: eight busy cycles, done in the ninth.
    start_op(8'd100, 8'd7);
    wait_done(n, bc);
    check("d100_7_lat", 32'(n), 32'd8);
    check("d100_7_busy", 32'(bc), 32'd8);
    check_result("d100_7", 14, 2, 1'b1, 1'b0, 1'b0);
    step();
    check("d100_7_done_1cyc", 32'(u_if.done), 32'd0);

    start_op(8'd255, 8'd1);
    wait_done(n, bc);
    check("d255_1_lat", 32'(n), 32'd8);
    check_result("d255_1", 255, 0, 1'b0, 1'b0, 1'b0);
    step();

    start_op(8'd0, 8'd3);
    wait_done(n, bc);
    check_result("d0_3", 0, 0, 1'b0, 1'b0, 1'b1);
    step();

    start_op(8'd5, 8'd9);
    wait_done(n, bc);
    check_result("d5_9", 0, 5, 1'b1, 1'b0, 1'b1);
    step();

    // Divide by zero: no RUN phase at all.
    start_op(8'd42, 8'd0);
    wait_done(n, bc);
    check("d42_0_lat", 32'(n), 32'd0);
    check("d42_0_busy", 32'(bc), 32'd0);
    check_result("d42_0", 255, 42, 1'b1, 1'b1, 1'b0);
    step();
    check("d42_0_done_1cyc", 32'(u_if.done), 32'd0);

    // Start during RUN is ignored; operand changes do not disturb the op.
    start_op(8'd200, 8'd10);
    step();
    step();
    u_if.start    = 1'b1;
    u_if.dividend = 8'd7;
    u_if.divisor  = 8'd7;
    step();
    u_if.start = 1'b0;
    check("ign_busy", 32'(u_if.busy), 32'd1);
    wait_done(n, bc);
    check("ign_lat", 32'(n), 32'd5);
    check_result("d200_10", 20, 0, 1'b0, 1'b0, 1'b0);
    step();

    // Back-to-back: second start lands in the FIN cycle of the first.
    start_op(8'd100, 8'd7);
    wait_done(n, bc);
    check_result("b2b_first", 14, 2, 1'b1, 1'b0, 1'b0);
    start_op(8'd64, 8'd8);
    check("b2b_hold_q0", 32'(u_if.quotient), 32'd14);
    step();
    step();
    step();
    check("b2b_hold_q", 32'(u_if.quotient), 32'd14);
    check("b2b_hold_r", 32'(u_if.remainder), 32'd2);
    wait_done(n, bc);
    check("b2b_lat", 32'(n), 32'd5);
    check_result("d64_8", 8, 0, 1'b0, 1'b0, 1'b0);
    step();

    // Asynchronous reset mid-cycle during the 4th RUN cycle.
    start_op(8'd200, 8'd10);
    step();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(u_if.busy), 32'd0);
    check("arst_done", 32'(u_if.done), 32'd0);
    check_result("arst", 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (u_if.done) done_cnt++;
    end
    check("arst_no_done", 32'(done_cnt), 32'd0);

    start_op(8'd9, 8'd2);
    wait_done(n, bc);
    check("d9_2_lat", 32'(n), 32'd8);
    check_result("d9_2", 4, 1, 1'b1, 1'b0, 1'b0);
    step();

    check("busy_done_overlap", 32'(overlap_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
